// File: rtl/per2axi_res_channel_pkg.sv
// Shared definitions for the per2axi response path: AXI response encodings,
// outstanding-counter sizing and the arbiter grant encoding.
package per2axi_res_channel_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam int unsigned          CNT_WIDTH = 8;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic {
        GRANT_R = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    // A 64-bit beat carries two 32-bit words; address bit 2 picks the upper one.
    function automatic logic [31:0] select_lane(input logic [63:0] data, input logic align);
        return align ? data[63:32] : data[31:0];
    endfunction

endpackage

// File: rtl/per2axi_res_buf.sv
// Single-entry response buffer: loads on an AXI handshake, empties when the
// arbiter selects it, and can accept a new beat in the same cycle it is popped.
module per2axi_res_buf #(
    parameter int unsigned WIDTH = 38
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             ready_o
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ready_o = !valid_q || pop_i;

endmodule

// File: rtl/per2axi_res_channel.sv
// Response path of the peripheral-to-AXI bridge: buffers AXI R and B beats,
// restores peripheral ID / read lane from the ID table and arbitrates onto the peripheral bus.
module per2axi_res_channel
    import per2axi_res_channel_pkg::*;
#(
    parameter int unsigned PER_ID_WIDTH   = 5,
    parameter int unsigned AXI_ID_WIDTH   = 3,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_USER_WIDTH = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      axi_master_r_valid_i,
    output logic                      axi_master_r_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i,
    input  logic [1:0]                axi_master_r_resp_i,
    input  logic                      axi_master_r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i,

    input  logic                      axi_master_b_valid_i,
    output logic                      axi_master_b_ready_o,
    input  logic [1:0]                axi_master_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i,

    output logic                      per_slave_r_valid_o,
    output logic                      per_slave_r_opc_o,
    output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
    output logic [31:0]               per_slave_r_rdata_o,

    input  logic                      trans_req_i,
    input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
    input  logic [PER_ID_WIDTH-1:0]   trans_per_id_i,
    input  logic [31:0]               trans_add_i,
    output logic                      trans_full_o,
    output logic                      trans_busy_o
);

    localparam int unsigned TBL_DEPTH = 2 ** AXI_ID_WIDTH;

    typedef struct packed {
        logic [PER_ID_WIDTH-1:0] per_id;
        logic                    align;
    } tbl_entry_t;

    typedef struct packed {
        logic [PER_ID_WIDTH-1:0] per_id;
        logic                    opc;
        logic [31:0]             rdata;
    } resp_t;

    localparam int unsigned RESP_W = $bits(resp_t);

    tbl_entry_t table_d [TBL_DEPTH];
    tbl_entry_t table_q [TBL_DEPTH];

    tbl_entry_t r_entry, b_entry;
    resp_t      r_load_data, b_load_data;
    resp_t      r_buf_data, b_buf_data, out_resp;
    logic       r_buf_valid, b_buf_valid;
    logic       r_load, b_load, pop_r, pop_b;

    grant_e     last_grant_d, last_grant_q;

    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

    always_comb begin
        table_d = table_q;
        if (trans_req_i) begin
            table_d[trans_id_i] = '{per_id: trans_per_id_i, align: trans_add_i[2]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            table_q <= table_d;
        end
    end

    // Lookups read the registered table, so a same-cycle issue to the same ID is not seen yet.
    assign r_entry = table_q[axi_master_r_id_i];
    assign b_entry = table_q[axi_master_b_id_i];

    assign r_load_data = '{per_id: r_entry.per_id,
                           opc:    axi_master_r_resp_i[1],
                           rdata:  select_lane(axi_master_r_data_i, r_entry.align)};
    assign b_load_data = '{per_id: b_entry.per_id,
                           opc:    axi_master_b_resp_i[1],
                           rdata:  32'h0};

    assign r_load = axi_master_r_valid_i && axi_master_r_ready_o;
    assign b_load = axi_master_b_valid_i && axi_master_b_ready_o;

    per2axi_res_buf #(.WIDTH(RESP_W)) i_r_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (r_load),
        .data_i  (r_load_data),
        .pop_i   (pop_r),
        .valid_o (r_buf_valid),
        .data_o  (r_buf_data),
        .ready_o (axi_master_r_ready_o)
    );

    per2axi_res_buf #(.WIDTH(RESP_W)) i_b_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (b_load),
        .data_i  (b_load_data),
        .pop_i   (pop_b),
        .valid_o (b_buf_valid),
        .data_o  (b_buf_data),
        .ready_o (axi_master_b_ready_o)
    );

    // Round-robin only matters on a tie; the grant history moves only then.
    assign pop_r = r_buf_valid && (!b_buf_valid || (last_grant_q == GRANT_B));
    assign pop_b = b_buf_valid && (!r_buf_valid || (last_grant_q == GRANT_R));

    always_comb begin
        last_grant_d = last_grant_q;
        if (r_buf_valid && b_buf_valid) begin
            last_grant_d = pop_r ? GRANT_R : GRANT_B;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= GRANT_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        per_slave_r_valid_o = 1'b0;
        out_resp            = '0;
        if (pop_r) begin
            per_slave_r_valid_o = 1'b1;
            out_resp            = r_buf_data;
        end else if (pop_b) begin
            per_slave_r_valid_o = 1'b1;
            out_resp            = b_buf_data;
        end
    end

    assign per_slave_r_opc_o   = out_resp.opc;
    assign per_slave_r_id_o    = out_resp.per_id;
    assign per_slave_r_rdata_o = out_resp.rdata;

    always_comb begin
        cnt_d = cnt_q;
        if (trans_req_i && !per_slave_r_valid_o && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!trans_req_i && per_slave_r_valid_o && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign trans_full_o = (cnt_q == CNT_MAX);
    assign trans_busy_o = (cnt_q != '0);

    no_issue_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(trans_req_i && trans_full_o));
    no_response_when_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(per_slave_r_valid_o && !trans_busy_o));

    logic unused_inputs;
    assign unused_inputs = ^{axi_master_r_last_i, axi_master_r_user_i, axi_master_b_user_i,
                             axi_master_r_resp_i[0], axi_master_b_resp_i[0],
                             trans_add_i[31:3], trans_add_i[1:0]};

endmodule

// File: tb/tb_per2axi_res_channel.sv
// Directed bench for per2axi_res_channel: lane selection, ID restore, R/B
// round-robin, outstanding-counter limits and asynchronous reset.
module tb_per2axi_res_channel;
    import per2axi_res_channel_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        r_valid, r_ready, r_last;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic [2:0]  r_id;
    logic [5:0]  r_user;
    logic        b_valid, b_ready;
    logic [1:0]  b_resp;
    logic [2:0]  b_id;
    logic [5:0]  b_user;
    logic        per_valid, per_opc;
    logic [4:0]  per_id;
    logic [31:0] per_rdata;
    logic        trans_req;
    logic [2:0]  trans_id;
    logic [4:0]  trans_per_id;
    logic [31:0] trans_add;
    logic        trans_full, trans_busy;

    int errors = 0;
    int checks = 0;

    per2axi_res_channel #(
        .PER_ID_WIDTH   (5),
        .AXI_ID_WIDTH   (3),
        .AXI_DATA_WIDTH (64),
        .AXI_USER_WIDTH (6)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .axi_master_r_valid_i (r_valid),
        .axi_master_r_ready_o (r_ready),
        .axi_master_r_data_i  (r_data),
        .axi_master_r_resp_i  (r_resp),
        .axi_master_r_last_i  (r_last),
        .axi_master_r_id_i    (r_id),
        .axi_master_r_user_i  (r_user),
        .axi_master_b_valid_i (b_valid),
        .axi_master_b_ready_o (b_ready),
        .axi_master_b_resp_i  (b_resp),
        .axi_master_b_id_i    (b_id),
        .axi_master_b_user_i  (b_user),
        .per_slave_r_valid_o  (per_valid),
        .per_slave_r_opc_o    (per_opc),
        .per_slave_r_id_o     (per_id),
        .per_slave_r_rdata_o  (per_rdata),
        .trans_req_i          (trans_req),
        .trans_id_i           (trans_id),
        .trans_per_id_i       (trans_per_id),
        .trans_add_i          (trans_add),
        .trans_full_o         (trans_full),
        .trans_busy_o         (trans_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [2:0] rid, input logic [63:0] rdat,
                                 input logic [1:0] rrsp, input logic bv, input logic [2:0] bid,
                                 input logic [1:0] brsp, input logic treq, input logic [2:0] tid,
                                 input logic [4:0] tper, input logic [31:0] tadd);
        r_valid      = rv;
        r_id         = rid;
        r_data       = rdat;
        r_resp       = rrsp;
        r_last       = rv;
        r_user       = 6'h2a;
        b_valid      = bv;
        b_id         = bid;
        b_resp       = brsp;
        b_user       = 6'h15;
        trans_req    = treq;
        trans_id     = tid;
        trans_per_id = tper;
        trans_add    = tadd;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 3'd0, 64'h0, 2'b00, 1'b0, 3'd0, 2'b00, 1'b0, 3'd0, 5'd0, 32'h0);
    endtask

    task automatic issue(input logic [2:0] tid, input logic [4:0] tper, input logic [31:0] tadd);
        applyStimulus(1'b0, 3'd0, 64'h0, 2'b00, 1'b0, 3'd0, 2'b00, 1'b1, tid, tper, tadd);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResp(input string tag, input logic v, input logic [4:0] id,
                             input logic [31:0] rdata, input logic opc);
        checkOutput({tag, " valid"}, {31'd0, per_valid}, {31'd0, v});
        checkOutput({tag, " id"},    {27'd0, per_id},    {27'd0, id});
        checkOutput({tag, " rdata"}, per_rdata,          rdata);
        checkOutput({tag, " opc"},   {31'd0, per_opc},   {31'd0, opc});
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResp("reset", 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("reset r_ready", {31'd0, r_ready}, 32'd1);
        checkOutput("reset b_ready", {31'd0, b_ready}, 32'd1);
        checkOutput("reset full", {31'd0, trans_full}, 32'd0);
        checkOutput("reset busy", {31'd0, trans_busy}, 32'd0);
        rst_n = 1'b1;
        nextCycle();

        // Read, upper lane, OKAY.
        issue(3'd2, 5'd5, 32'h0000_1004);
        nextCycle();
        applyStimulus(1'b1, 3'd2, 64'h1111_2222_3333_4444, AXI_RESP_OKAY,
                      1'b0, 3'd0, 2'b00, 1'b0, 3'd0, 5'd0, 32'h0);
        @(negedge clk);
        checkOutput("rd1 no early valid", {31'd0, per_valid}, 32'd0);
        checkOutput("rd1 busy", {31'd0, trans_busy}, 32'd1);
        checkOutput("rd1 r_ready", {31'd0, r_ready}, 32'd1);
        nextCycle();
        idle();
        @(negedge clk);
        checkResp("rd1", 1'b1, 5'd5, 32'h1111_2222, 1'b0);
        nextCycle();

        // Read, lower lane, SLVERR; same-cycle re-issue of ID 2 must not affect this lookup.
        issue(3'd2, 5'd5, 32'h0000_1000);
        nextCycle();
        applyStimulus(1'b1, 3'd2, 64'h1111_2222_3333_4444, AXI_RESP_SLVERR,
                      1'b0, 3'd0, 2'b00, 1'b1, 3'd2, 5'd9, 32'h0000_0004);
        nextCycle();
        idle();
        @(negedge clk);
        checkResp("rd2", 1'b1, 5'd5, 32'h3333_4444, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 3'd2, 64'hAAAA_BBBB_CCCC_DDDD, AXI_RESP_OKAY,
                      1'b0, 3'd0, 2'b00, 1'b0, 3'd0, 5'd0, 32'h0);
        nextCycle();
        idle();
        @(negedge clk);
        checkResp("rd3", 1'b1, 5'd9, 32'hAAAA_BBBB, 1'b0);
        nextCycle();
        @(negedge clk);
        checkOutput("rd3 busy after", {31'd0, trans_busy}, 32'd0);
        nextCycle();

        // Write response.
        issue(3'd1, 5'd3, 32'h0000_2000);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 64'h0, 2'b00, 1'b1, 3'd1, AXI_RESP_OKAY, 1'b0, 3'd0, 5'd0, 32'h0);
        @(negedge clk);
        checkOutput("wr b_ready", {31'd0, b_ready}, 32'd1);
        nextCycle();
        idle();
        @(negedge clk);
        checkResp("wr", 1'b1, 5'd3, 32'h0, 1'b0);
        nextCycle();
        @(negedge clk);
        checkOutput("wr busy after", {31'd0, trans_busy}, 32'd0);
        checkOutput("wr valid after", {31'd0, per_valid}, 32'd0);
        nextCycle();

        // Continuous R and B: 12 outstanding, 7 responses, strict R/B alternation.
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) issue(3'd4, 5'd10, 32'h0000_0004);
            else            issue(3'd5, 5'd20, 32'h0000_0000);
            nextCycle();
        end
        for (int c = 0; c < 9; c++) begin
            applyStimulus(c < 6, 3'd4, 64'h0000_0007_0000_0000, AXI_RESP_OKAY,
                          c < 6, 3'd5, AXI_RESP_SLVERR, 1'b0, 3'd0, 5'd0, 32'h0);
            @(negedge clk);
            if (c == 0 || c == 8)
                checkResp($sformatf("rr c%0d", c), 1'b0, 5'd0, 32'h0, 1'b0);
            else if (c % 2 == 1)
                checkResp($sformatf("rr c%0d", c), 1'b1, 5'd10, 32'h7, 1'b0);
            else
                checkResp($sformatf("rr c%0d", c), 1'b1, 5'd20, 32'h0, 1'b1);
            if (c == 1) begin
                checkOutput("rr c1 r_ready", {31'd0, r_ready}, 32'd1);
                checkOutput("rr c1 b_ready", {31'd0, b_ready}, 32'd0);
            end
            nextCycle();
        end

        // Counter is at 5; fill to 254, then 255.
        for (int i = 0; i < 249; i++) begin
            issue(3'd6, 5'd1, 32'h0);
            nextCycle();
        end
        idle();
        @(negedge clk);
        checkOutput("cnt254 full", {31'd0, trans_full}, 32'd0);
        nextCycle();
        issue(3'd6, 5'd1, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 64'h0, 2'b00, 1'b1, 3'd5, AXI_RESP_SLVERR, 1'b0, 3'd0, 5'd0, 32'h0);
        @(negedge clk);
        checkOutput("cnt255 full", {31'd0, trans_full}, 32'd1);
        nextCycle();
        idle();
        @(negedge clk);
        checkResp("full resp", 1'b1, 5'd20, 32'h0, 1'b1);
        checkOutput("full still set", {31'd0, trans_full}, 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("full cleared", {31'd0, trans_full}, 32'd0);
        applyStimulus(1'b0, 3'd0, 64'h0, 2'b00, 1'b1, 3'd5, AXI_RESP_OKAY, 1'b0, 3'd0, 5'd0, 32'h0);
        nextCycle();
        issue(3'd6, 5'd1, 32'h0);
        @(negedge clk);
        checkOutput("req+resp valid", {31'd0, per_valid}, 32'd1);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("req+resp unchanged", {31'd0, trans_full}, 32'd0);
        nextCycle();
        issue(3'd6, 5'd1, 32'h0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("refill full", {31'd0, trans_full}, 32'd1);
        nextCycle();

        // Fill both buffers, then reset asynchronously mid-cycle.
        applyStimulus(1'b1, 3'd4, 64'h0000_0007_0000_0000, AXI_RESP_OKAY,
                      1'b1, 3'd5, AXI_RESP_OKAY, 1'b0, 3'd0, 5'd0, 32'h0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("pre-reset valid", {31'd0, per_valid}, 32'd1);
        checkOutput("pre-reset r_ready", {31'd0, r_ready & b_ready}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        checkResp("async reset", 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("async reset r_ready", {31'd0, r_ready}, 32'd1);
        checkOutput("async reset b_ready", {31'd0, b_ready}, 32'd1);
        checkOutput("async reset busy", {31'd0, trans_busy}, 32'd0);
        checkOutput("async reset full", {31'd0, trans_full}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("post-reset valid c%0d", c), {31'd0, per_valid}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
